// File: rtl/dc_fifo_pkg.sv
// Shared helpers for the dual-clock FIFO.
//   bin2gray / gray2bin : pointer encoding conversions. Both take the pointer
//   width (ASIZE+1 at the call site) and ignore any bits above it, so one
//   definition serves every FIFO size up to PtrMaxW bits.
package dc_fifo_pkg;

    localparam int unsigned PtrMaxW = 32;

    function automatic logic [PtrMaxW-1:0] width_mask(input int unsigned w);
        logic [PtrMaxW-1:0] ones;
        ones = '1;
        return (w >= PtrMaxW) ? ones : ~(ones << w);
    endfunction

    function automatic logic [PtrMaxW-1:0] bin2gray(input logic [PtrMaxW-1:0] b,
                                                    input int unsigned        w);
        logic [PtrMaxW-1:0] bm;
        bm = b & width_mask(w);
        return bm ^ (bm >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [PtrMaxW-1:0] gray2bin(input logic [PtrMaxW-1:0] g,
                                                    input int unsigned        w);
        logic [PtrMaxW-1:0] gm;
        logic [PtrMaxW-1:0] b;
        gm = g & width_mask(w);
        b  = '0;
        for (int i = 0; i < PtrMaxW; i++) begin
            b[i] = ^(gm >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/dc_fifo_sync2.sv
// Two-flop synchronizer for Gray-coded pointers crossing into clk_i's domain.
//   clk_i  : destination clock
//   rst_ni : synchronous active-low reset (clears both stages)
//   d_i    : value from the source domain (must be a registered Gray code)
//   q_o    : synchronized value, two clk_i edges behind d_i
module dc_fifo_sync2 #(
    parameter int unsigned W = 6
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/dc_fifo_async.sv
// Dual-clock FIFO moving DSIZE-bit words from the wclk domain to the rclk domain.
// Depth is 2**ASIZE; ASIZE must be at least 2.
//   wclk, rclk : write / read clocks
//   rst_n      : synchronous active-low reset, sampled by each domain on its own clock
//   wdata,w_en : write word and request; w_full blocks writes (combinational)
//   wuse       : occupancy seen from the write side (registered)
//   rdata,r_ok : read word and its valid strobe, one rclk after the accepting edge
//   r_en       : read request; r_empty blocks reads (combinational)
//   ruse       : occupancy seen from the read side (registered)
// Occupancy counts wrap to 0 at exactly 2**ASIZE entries; w_full tells full from empty.
module dc_fifo_async
    import dc_fifo_pkg::*;
#(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned ASIZE = 5
) (
    input  logic             wclk,
    input  logic             rclk,
    input  logic             rst_n,
    input  logic [DSIZE-1:0] wdata,
    input  logic             w_en,
    output logic             w_full,
    output logic [ASIZE-1:0] wuse,
    output logic [DSIZE-1:0] rdata,
    output logic             r_empty,
    input  logic             r_en,
    output logic             r_ok,
    output logic [ASIZE-1:0] ruse
);

    localparam int unsigned PtrW  = ASIZE + 1;
    localparam int unsigned Depth = 2 ** ASIZE;

    logic [DSIZE-1:0] mem_q [Depth];

    // ---------------------------------------------------------------- write side
    logic [PtrW-1:0]  wptr_q,  wptr_d;
    logic [PtrW-1:0]  wgray_q, wgray_d;
    logic [ASIZE-1:0] wuse_q,  wuse_d;
    logic [PtrW-1:0]  rgray_sync;
    logic [PtrW-1:0]  rbin_sync;
    logic             w_accept;

    dc_fifo_sync2 #(
        .W (PtrW)
    ) u_sync_rptr (
        .clk_i  (wclk),
        .rst_ni (rst_n),
        .d_i    (rgray_q),
        .q_o    (rgray_sync)
    );

    // Full when the writer is exactly one lap ahead: in Gray code that means the
    // top two bits differ and the rest match.
    assign w_full = (wgray_q == {~rgray_sync[PtrW-1 -: 2], rgray_sync[PtrW-3:0]});

    always_comb begin
        w_accept  = w_en & ~w_full;
        wptr_d    = wptr_q + PtrW'(w_accept);
        wgray_d   = PtrW'(bin2gray(PtrMaxW'(wptr_d), PtrW));
        rbin_sync = PtrW'(gray2bin(PtrMaxW'(rgray_sync), PtrW));
        wuse_d    = wptr_q[ASIZE-1:0] - rbin_sync[ASIZE-1:0];
    end

    always_ff @(posedge wclk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            wgray_q <= '0;
            wuse_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            wgray_q <= wgray_d;
            wuse_q  <= wuse_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge wclk) begin
        if (rst_n && w_accept) begin
            mem_q[wptr_q[ASIZE-1:0]] <= wdata;
        end
    end

    assign wuse = wuse_q;

    // ----------------------------------------------------------------- read side
    logic [PtrW-1:0]  rptr_q,  rptr_d;
    logic [PtrW-1:0]  rgray_q, rgray_d;
    logic [ASIZE-1:0] ruse_q,  ruse_d;
    logic [DSIZE-1:0] rdata_q, rdata_d;
    logic             r_ok_q,  r_ok_d;
    logic [PtrW-1:0]  wgray_sync;
    logic [PtrW-1:0]  wbin_sync;
    logic             r_accept;

    dc_fifo_sync2 #(
        .W (PtrW)
    ) u_sync_wptr (
        .clk_i  (rclk),
        .rst_ni (rst_n),
        .d_i    (wgray_q),
        .q_o    (wgray_sync)
    );

    assign r_empty = (rgray_q == wgray_sync);

    always_comb begin
        r_accept  = r_en & ~r_empty;
        rptr_d    = rptr_q + PtrW'(r_accept);
        rgray_d   = PtrW'(bin2gray(PtrMaxW'(rptr_d), PtrW));
        wbin_sync = PtrW'(gray2bin(PtrMaxW'(wgray_sync), PtrW));
        ruse_d    = wbin_sync[ASIZE-1:0] - rptr_q[ASIZE-1:0];
        rdata_d   = rdata_q;
        r_ok_d    = r_accept;
        if (r_accept) begin
            rdata_d = mem_q[rptr_q[ASIZE-1:0]];
        end
    end

    always_ff @(posedge rclk) begin
        if (!rst_n) begin
            rptr_q  <= '0;
            rgray_q <= '0;
            ruse_q  <= '0;
            rdata_q <= '0;
            r_ok_q  <= 1'b0;
        end else begin
            rptr_q  <= rptr_d;
            rgray_q <= rgray_d;
            ruse_q  <= ruse_d;
            rdata_q <= rdata_d;
            r_ok_q  <= r_ok_d;
        end
    end

    assign rdata = rdata_q;
    assign r_ok  = r_ok_q;
    assign ruse  = ruse_q;

endmodule

// File: tb/tb_dc_fifo_async.sv
// Directed bench for dc_fifo_async: a scoreboard queue gets each word the bench
// expects to be accepted; a monitor on rclk pops and compares on every r_ok.
// Inputs change only at even times; both clocks sample at odd times.
module tb_dc_fifo_async;

    logic       wclk = 1'b0;
    logic       rclk = 1'b0;
    logic       rst_n;
    logic [7:0] wdata;
    logic       w_en;
    logic       w_full;
    logic [4:0] wuse;
    logic [7:0] rdata;
    logic       r_empty;
    logic       r_en;
    logic       r_ok;
    logic [4:0] ruse;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    logic [7:0]  sb[$];

    always #5 wclk = ~wclk;
    always #3 rclk = ~rclk;

    dc_fifo_async #(
        .DSIZE (8),
        .ASIZE (5)
    ) dut (
        .wclk    (wclk),
        .rclk    (rclk),
        .rst_n   (rst_n),
        .wdata   (wdata),
        .w_en    (w_en),
        .w_full  (w_full),
        .wuse    (wuse),
        .rdata   (rdata),
        .r_empty (r_empty),
        .r_en    (r_en),
        .r_ok    (r_ok),
        .ruse    (ruse)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] d);
        @(negedge wclk);
        chk("not_full_before_write", {31'd0, w_full}, 32'd0);
        w_en  = 1'b1;
        wdata = d;
        sb.push_back(d);
    endtask

    task automatic wr_stop();
        @(negedge wclk);
        w_en = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge wclk);
            n++;
        end
        chk(tag, sb.size(), 32'd0);
    endtask

    // Read-side scoreboard check.
    always @(posedge rclk) begin
        #1;
        if (r_ok === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_r_ok", {31'd0, r_ok}, 32'd0);
            end else begin
                logic [7:0] exp_d;
                exp_d = sb.pop_front();
                chk("rdata", {24'd0, rdata}, {24'd0, exp_d});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        w_en  = 1'b0;
        r_en  = 1'b0;
        wdata = '0;
        repeat (4) @(negedge wclk);
        chk("rst_w_full",  {31'd0, w_full},  32'd0);
        chk("rst_r_empty", {31'd0, r_empty}, 32'd1);
        chk("rst_wuse",    {27'd0, wuse},    32'd0);
        chk("rst_ruse",    {27'd0, ruse},    32'd0);
        chk("rst_r_ok",    {31'd0, r_ok},    32'd0);
        chk("rst_rdata",   {24'd0, rdata},   32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge wclk);

        // Stream: reader is faster, so the FIFO never fills.
        r_en = 1'b1;
        for (int i = 0; i < 40; i++) wr(8'(i));
        wr_stop();
        wait_drain("stream_drained", 200);
        r_en = 1'b0;
        repeat (4) @(negedge wclk);

        // Fill to 32, then try a 33rd write that must be dropped.
        for (int i = 0; i < 32; i++) wr(8'(i));
        @(negedge wclk);
        chk("full_after_32", {31'd0, w_full}, 32'd1);
        w_en  = 1'b1;
        wdata = 8'd99;
        @(negedge wclk);
        w_en = 1'b0;
        chk("full_after_33rd", {31'd0, w_full}, 32'd1);
        repeat (3) @(negedge wclk);
        chk("full_wuse_wraps", {27'd0, wuse}, 32'd0);
        repeat (5) @(negedge rclk);
        chk("full_ruse_wraps", {27'd0, ruse},    32'd0);
        chk("full_not_empty",  {31'd0, r_empty}, 32'd0);

        // Drain: exactly 0..31, then reads stall with rdata holding 31.
        @(negedge wclk);
        r_en = 1'b1;
        wait_drain("drain_done", 150);
        repeat (3) @(negedge wclk);
        chk("drain_empty",      {31'd0, r_empty}, 32'd1);
        chk("drain_r_ok_low",   {31'd0, r_ok},    32'd0);
        chk("drain_rdata_hold", {24'd0, rdata},   32'd31);
        chk("drain_not_full",   {31'd0, w_full},  32'd0);
        r_en = 1'b0;

        // Wrap-around: three fill/drain rounds of 24 words.
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 24; i++) wr(8'(8'h40 + c * 24 + i));
            wr_stop();
            repeat (4) @(negedge wclk);
            chk("wrap_ruse",      {27'd0, ruse},    32'd24);
            chk("wrap_wuse",      {27'd0, wuse},    32'd24);
            chk("wrap_not_empty", {31'd0, r_empty}, 32'd0);
            r_en = 1'b1;
            wait_drain("wrap_drained", 150);
            repeat (3) @(negedge wclk);
            chk("wrap_empty",    {31'd0, r_empty}, 32'd1);
            chk("wrap_not_full", {31'd0, w_full},  32'd0);
            r_en = 1'b0;
        end

        // Partial occupancy: 5 in, 2 out.
        for (int i = 0; i < 5; i++) wr(8'(8'hC0 + i));
        wr_stop();
        repeat (5) @(negedge rclk);
        chk("part_ruse5", {27'd0, ruse}, 32'd5);
        chk("part_wuse5", {27'd0, wuse}, 32'd5);
        @(negedge rclk);
        r_en = 1'b1;
        repeat (2) @(negedge rclk);
        r_en = 1'b0;
        repeat (4) @(negedge wclk);
        chk("part_wuse3", {27'd0, wuse}, 32'd3);
        chk("part_ruse3", {27'd0, ruse}, 32'd3);
        chk("part_sb3",   sb.size(),     32'd3);

        // Reset with 10 entries stored.
        for (int i = 0; i < 7; i++) wr(8'(8'hD0 + i));
        wr_stop();
        repeat (4) @(negedge wclk);
        chk("pre_rst_ruse", {27'd0, ruse}, 32'd10);
        rst_n = 1'b0;
        repeat (4) @(negedge wclk);
        sb.delete();
        rst_n = 1'b1;
        repeat (3) @(negedge wclk);
        chk("post_rst_empty", {31'd0, r_empty}, 32'd1);
        chk("post_rst_full",  {31'd0, w_full},  32'd0);
        chk("post_rst_wuse",  {27'd0, wuse},    32'd0);
        chk("post_rst_ruse",  {27'd0, ruse},    32'd0);
        chk("post_rst_r_ok",  {31'd0, r_ok},    32'd0);
        wr(8'hA5);
        wr_stop();
        r_en = 1'b1;
        wait_drain("post_rst_readback", 50);
        repeat (2) @(negedge wclk);
        chk("post_rst_rdata", {24'd0, rdata}, 32'hA5);
        r_en = 1'b0;
        repeat (4) @(negedge wclk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
